// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - producer/consumer handshake, control and status bundle for fifo_sync_param
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 4
);
  logic                  flush;
  logic                  clr_err;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_en;
  logic                  rd_val;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CNT_W-1:0]      count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clr_err, wr_en, wr_data, rd_en,
    input  wr_ready, rd_val, rd_data, count, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, wr_data, rd_en,
    output wr_ready, rd_val, rd_data, count, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock FIFO, any depth >= 2, thresholds, FWFT option, flush, sticky errors
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter bit FWFT       = 1'b0,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  fifo_sync_param_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_ready, rd_val, wr_acc, rd_acc;

  // Depth need not be a power of two, so pointers wrap at DEPTH-1 explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ready    = (count_q != FULL_CNT);
    rd_val      = (count_q != '0);
    wr_acc      = bus.wr_en & wr_ready & ~bus.flush;
    rd_acc      = bus.rd_en & rd_val & ~bus.flush;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q & ~bus.clr_err;
    underflow_d = underflow_q & ~bus.clr_err;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) tail_d = ptr_inc(tail_q);
      if (rd_acc) head_d = ptr_inc(head_q);
      if (wr_acc && !rd_acc) count_d = count_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
      // Error set is applied after the clear so a same-cycle new error wins.
      if (bus.wr_en && !wr_ready) overflow_d = 1'b1;
      if (bus.rd_en && !rd_val) underflow_d = 1'b1;
      if (!FWFT && rd_acc) rd_data_d = mem_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem_q[tail_q] <= bus.wr_data;
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.rd_val       = rd_val;
  assign bus.rd_data      = (FWFT && rd_val) ? mem_q[head_q] : rd_data_q;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
